// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared definitions for the instruction phase sequencer: state codes,
// phase width and the default MEM timeout.
package cpu_phase_sequencer_pkg;

    localparam int SEQ_PHASE_W         = 3;
    localparam int SEQ_MEM_TIMEOUT_DEF = 15;

    typedef enum logic [SEQ_PHASE_W-1:0] {
        SEQ_HALT   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5
    } seq_state_e;

endpackage

// File: rtl/cpu_phase_sequencer_timeout.sv
// MEM-phase watchdog: cleared on MEM entry, counts cycles without ready and
// flags expiry on the cycle that would bring the count to LIMIT.
module seq_timeout_counter #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase sequencer: FETCH, DECODE, EXEC, optional MEM, WB.
// Optional single-step input enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_phase_sequencer
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = SEQ_MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   halt_req,
    input  logic                   mem_access,
    input  logic                   reg_write,
    input  logic                   mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic                   if_en,
    output logic                   dec_en,
    output logic                   ex_en,
    output logic                   mem_en,
    output logic                   reg_we,
    output logic                   pc_en,
    output logic                   halted,
    output logic                   bus_err,
    output logic [SEQ_PHASE_W-1:0] phase,
    output logic [CNT_W-1:0]       instret
);

    seq_state_e       state_q, state_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             tmo_load, tmo_en, tmo_expire;
    logic             stop_after_wb;

    seq_timeout_counter #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (tmo_load),
        .en_i    (tmo_en),
        .expire_o(tmo_expire)
    );

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q, single_q, single_d;
    logic step_rise;
    assign step_rise = step & ~step_q;
    assign stop_after_wb = halt_req | ~run | single_q;
`else
    assign stop_after_wb = halt_req | ~run;
`endif

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bus_err_d = bus_err_q;
        instret_d = instret_q;
        tmo_load  = 1'b0;
        tmo_en    = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        single_d  = single_q;
`endif
        case (state_q)
            SEQ_HALT: begin
                if (!bus_err_q) begin
                    if (run && !halt_req) state_d = SEQ_FETCH;
`ifdef SEQ_SINGLE_STEP_EN
                    if (step_rise) begin
                        state_d  = SEQ_FETCH;
                        single_d = 1'b1;
                    end
`endif
                end
            end
            SEQ_FETCH:  state_d = SEQ_DECODE;
            SEQ_DECODE: state_d = SEQ_EXEC;
            SEQ_EXEC: begin
                if (mem_access) begin
                    state_d  = SEQ_MEM;
                    tmo_load = 1'b1;
                end else begin
                    state_d = SEQ_WB;
                end
            end
            SEQ_MEM: begin
                // Ready on the expiry cycle still completes the access.
                if (mem_ready) begin
                    state_d = SEQ_WB;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expire) begin
                        bus_err_d = 1'b1;
                        state_d   = SEQ_HALT;
`ifdef SEQ_SINGLE_STEP_EN
                        single_d  = 1'b0;
`endif
                    end
                end
            end
            SEQ_WB: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = stop_after_wb ? SEQ_HALT : SEQ_FETCH;
`ifdef SEQ_SINGLE_STEP_EN
                single_d  = 1'b0;
`endif
            end
            default: state_d = SEQ_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SEQ_HALT;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

`ifdef SEQ_SINGLE_STEP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q   <= 1'b0;
            single_q <= 1'b0;
        end else begin
            step_q   <= step;
            single_q <= single_d;
        end
    end
`endif

    assign if_en   = (state_q == SEQ_FETCH);
    assign dec_en  = (state_q == SEQ_DECODE);
    assign ex_en   = (state_q == SEQ_EXEC);
    assign mem_en  = (state_q == SEQ_MEM);
    assign pc_en   = (state_q == SEQ_WB);
    assign reg_we  = reg_write & (state_q == SEQ_WB);
    assign halted  = (state_q == SEQ_HALT);
    assign bus_err = bus_err_q;
    assign phase   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Self-checking bench for cpu_phase_sequencer: vector table, directed corner
// sequences and random instructions against a per-instruction trace model.
module tb_cpu_phase_sequencer;

    localparam int T     = 15;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0, halt_req = 1'b0, mem_access = 1'b0, reg_write = 1'b0, mem_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic step = 1'b0;
`endif
    logic if_en, dec_en, ex_en, mem_en, reg_we, pc_en, halted, bus_err;
    logic [2:0]       phase;
    logic [CNT_W-1:0] instret;

    int checks = 0;
    int errors = 0;
    int exp_instret = 0;
    bit exp_bus_err = 1'b0;

    cpu_phase_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .halt_req  (halt_req),
        .mem_access(mem_access),
        .reg_write (reg_write),
        .mem_ready (mem_ready),
`ifdef SEQ_SINGLE_STEP_EN
        .step      (step),
`endif
        .if_en     (if_en),
        .dec_en    (dec_en),
        .ex_en     (ex_en),
        .mem_en    (mem_en),
        .reg_we    (reg_we),
        .pc_en     (pc_en),
        .halted    (halted),
        .bus_err   (bus_err),
        .phase     (phase),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enables {if,dec,ex,mem,pc,reg_we,halted} implied by a phase code.
    function automatic logic [6:0] flags_for(input int ph, input logic rw);
        case (ph)
            1:       return 7'b1000000;
            2:       return 7'b0100000;
            3:       return 7'b0010000;
            4:       return 7'b0001000;
            5:       return {4'b0000, 1'b1, rw, 1'b0};
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic logic [6:0] act_flags();
        return {if_en, dec_en, ex_en, mem_en, pc_en, reg_we, halted};
    endfunction

    task automatic check_outputs(input string tag, input int ph, input logic rw);
        check({tag, " phase"},   64'(phase),       64'(ph));
        check({tag, " enables"}, 64'(act_flags()), 64'(flags_for(ph, rw)));
        check({tag, " instret"}, 64'(instret),     64'(exp_instret));
        check({tag, " bus_err"}, 64'(bus_err),     64'(exp_bus_err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        run = 1'b0; halt_req = 1'b0; mem_access = 1'b0; reg_write = 1'b0; mem_ready = 1'b0;
        #1;
        exp_instret = 0;
        exp_bus_err = 1'b0;
        check_outputs("reset", 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one instruction starting from an observed FETCH and leaves the DUT in FETCH.
    // d = MEM cycles before ready (d >= T means ready never comes).
    task automatic run_instr(input bit mem, input bit rw, input int d, input bit stop);
        int ph[$];
        int nm;
        int mem_idx;
        bit timed_out;
        timed_out = mem && (d >= T);
        nm = (d < T) ? d + 1 : T;
        ph.push_back(1); ph.push_back(2); ph.push_back(3);
        if (mem) for (int k = 0; k < nm; k++) ph.push_back(4);
        if (!timed_out) ph.push_back(5);
        mem_idx = 0;
        for (int i = 0; i < ph.size(); i++) begin
            run        = 1'b1;
            mem_access = mem;
            reg_write  = rw;
            halt_req   = stop && (ph[i] != 1);
            mem_ready  = (ph[i] == 4) && (mem_idx == d);
            #1;
            check_outputs("instr", ph[i], rw);
            if (ph[i] == 4) mem_idx++;
            tick();
            if (ph[i] == 5) exp_instret++;
        end
        mem_ready = 1'b0;
        if (timed_out) begin
            exp_bus_err = 1'b1;
            halt_req = 1'b0;
            for (int k = 0; k < 3; k++) begin
                #1;
                check_outputs("timeout_hold", 0, rw);
                tick();
            end
            do_reset();
            run = 1'b1;
            tick();
        end else if (stop) begin
            check_outputs("halt_entry", 0, rw);
            tick();
            check_outputs("halt_stay", 0, rw);
            halt_req = 1'b0;
            tick();
        end
    endtask

    typedef struct {
        logic       run, hr, ma, rw, rdy;
        logic [2:0] ph;
        logic [6:0] flags;
        int         ir;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000001, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000001, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 7'b1000000, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 7'b0100000, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 7'b0010000, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 7'b0000110, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 7'b1000000, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 7'b0100000, 1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 7'b0010000, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 7'b0001000, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 7'b0000100, 1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000001, 2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000001, 2};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 7'b1000000, 2};

        #1 rst = 1'b0;
        #2;
        check_outputs("reset0", 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            run = tbl[i].run; halt_req = tbl[i].hr; mem_access = tbl[i].ma;
            reg_write = tbl[i].rw; mem_ready = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d phase", i),   64'(phase),       64'(tbl[i].ph));
            check($sformatf("vec%0d enables", i), 64'(act_flags()), 64'(tbl[i].flags));
            check($sformatf("vec%0d instret", i), 64'(instret),     64'(tbl[i].ir));
        end

        // Free run of non-memory instructions: 1,2,3,5 repeating.
        do_reset();
        run = 1'b1;
        for (int c = 0; c < 12; c++) begin
            int seq_ph;
            tick();
            seq_ph = (c % 4 == 3) ? 5 : (c % 4) + 1;
            check_outputs("free_run", seq_ph, 1'b0);
            if (seq_ph == 5) exp_instret++;
        end
        tick();
        check("instret_after_12", 64'(instret), 64'd3);

        run_instr(1'b1, 1'b1, 3, 1'b0);
        run_instr(1'b0, 1'b1, 0, 1'b1);
        run_instr(1'b1, 1'b0, T - 1, 1'b0);
        run_instr(1'b1, 1'b1, 0, 1'b0);
        run_instr(1'b1, 1'b0, T, 1'b0);

        for (int n = 0; n < 60; n++) begin
            bit m, w, s;
            int d;
            m = 1'($urandom % 2);
            w = 1'($urandom % 2);
            s = ($urandom % 4) == 0;
            d = (($urandom % 8) == 0) ? T : int'($urandom % 5);
            run_instr(m, w, d, s);
        end

        // Asynchronous reset while in MEM.
        mem_access = 1'b1; mem_ready = 1'b0; reg_write = 1'b0; halt_req = 1'b0; run = 1'b1;
        tick(); tick(); tick();
        check_outputs("pre_rst_mem", 4, 1'b0);
        #1 rst = 1'b0;
        #1;
        exp_instret = 0;
        exp_bus_err = 1'b0;
        check_outputs("async_rst", 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        mem_access = 1'b0;
        tick();
        check_outputs("after_async_rst", 1, 1'b0);

`ifdef SEQ_SINGLE_STEP_EN
        do_reset();
        run = 1'b0;
        for (int p = 0; p < 2; p++) begin
            step = 1'b1;
            tick();
            check_outputs("step_fetch", 1, 1'b0);
            step = 1'b0;
            tick(); check_outputs("step_dec", 2, 1'b0);
            tick(); check_outputs("step_ex", 3, 1'b0);
            tick(); check_outputs("step_wb", 5, 1'b0);
            tick(); exp_instret++;
            check_outputs("step_halt", 0, 1'b0);
            tick(); check_outputs("step_halt2", 0, 1'b0);
        end
        check("step_instret", 64'(instret), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
- Multi-cycle phase controller for the single-cycle RISC-V datapath. It replaces the free-running 3-bit state counter that currently drives the PC enable.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB.
- Gates PC update, register write and data-memory strobes.
- Waits on a memory/IO ready handshake, supports halt, and counts retired instructions.
- Sits at top level between Controller outputs and PC, Decoder and Data_Mamory.

Parameters:
- MEM_TIMEOUT, 15, max cycles in MEM without mem_ready before a bus error (1..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- run  in  1  level; leaving HALT requires run=1.
- halt_req  in  1  level; halt after the current instruction retires.
- mem_access  in  1  Controller MemRead|MemWrite for the current instruction.
- reg_write  in  1  Controller RegWrite for the current instruction.
- mem_ready  in  1  data memory/IO completion, sampled only in MEM.
- if_en  out  1  instruction fetch enable.
- dec_en  out  1  decode/register-read enable.
- ex_en  out  1  ALU result capture enable.
- mem_en  out  1  qualifies MemRead/MemWrite strobes.
- reg_we  out  1  gated register-file write enable.
- pc_en  out  1  PC update enable.
- halted  out  1  sequencer is in HALT.
- bus_err  out  1  sticky memory-timeout flag.
- phase  out  3  current state encoding.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding: HALT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Codes 6 and 7 go to HALT next cycle.
- Reset (rst=0, asynchronous):
  - state=HALT, instret=0, bus_err=0, timeout counter=0.
  - halted=1; every other output is 0.
- Outputs are Moore, decoded from the state register only:
  - if_en=1 in FETCH.
  - dec_en=1 in DECODE.
  - ex_en=1 in EXEC.
  - mem_en=1 in MEM.
  - pc_en=1 in WB.
  - reg_we = reg_write & (state==WB).
  - halted = (state==HALT).
  - phase = state code.
- Transitions:
  - HALT -> FETCH when run=1, halt_req=0 and bus_err=0; otherwise stay.
  - FETCH -> DECODE -> EXEC, one cycle each, unconditional.
  - EXEC -> MEM if mem_access=1, else EXEC -> WB.
  - MEM -> WB when mem_ready=1. Minimum MEM dwell is 1 cycle, so ready in the first MEM cycle gives exactly 1 cycle.
  - MEM timeout: the counter resets to 0 on MEM entry and increments each MEM cycle without ready. When the counter reaches MEM_TIMEOUT with ready still low, set bus_err=1 and go MEM -> HALT. No WB: no PC update, no register write, no instret increment.
  - WB: instret increments by 1 (wraps modulo 2^CNT_W). Then WB -> HALT if halt_req=1 or run=0, else WB -> FETCH.
- Latency:
  - Non-memory instruction: 4 cycles (FETCH to WB inclusive).
  - Memory instruction: 5 + (ready delay) cycles.
- Simultaneous events:
  - mem_ready and timeout in the same cycle: ready wins, proceed to WB, bus_err unchanged.
  - halt_req asserted mid-instruction: takes effect only at WB. The current instruction always completes.
- bus_err clears only on reset. While set, HALT is never left.
- mem_access and reg_write are sampled every cycle. The datapath holds them stable because the PC changes only on pc_en.
- Reset mid-instruction: immediate abort to HALT. No partial write can occur, because reg_we and pc_en drop asynchronously with the state.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- When defined:
  - Extra input step (1 bit).
  - In HALT, a rising edge of step (edge detector registered, reset to 0) runs exactly one instruction, then returns to HALT regardless of run.
  - step is ignored outside HALT and while bus_err=1.
- When undefined: no step port; behaviour as above.

Decomposition:
- Shared package/header (variables.vh): state code constants SEQ_HALT..SEQ_WB, SEQ_PHASE_W=3, default MEM_TIMEOUT.
- One natural sub-module: seq_timeout_counter (load/enable/expire, 8-bit), instantiated once.
- Everything else is in the single FSM module.

Test Plan:
- Reset with rst=0, then release with run=1, halt_req=0, mem_access=0 -> phase sequence 1,2,3,5,1...; pc_en pulses every 4th cycle; instret=3 after 12 cycles.
- mem_access=1, mem_ready rises 3 cycles after MEM entry -> MEM lasts 4 cycles; mem_en=1 throughout; WB follows; instret increments by 1.
- mem_access=1, mem_ready held 0, MEM_TIMEOUT=15 -> HALT after MEM_TIMEOUT cycles in MEM; bus_err=1; no pc_en pulse; run=1 does not restart; only rst clears it.
- halt_req pulsed during DECODE -> instruction completes (reg_we=1 in WB if reg_write=1), then HALT; halted=1; deasserting halt_req with run=1 resumes at FETCH.
- rst driven 0 while in MEM with mem_en=1 -> all enables 0 immediately (asynchronous); instret=0; phase=0.
- SEQ_SINGLE_STEP_EN defined, run=0, two step pulses -> exactly two instructions retire (instret=2); sequencer returns to HALT after each.
